// File: rtl/mem_sched_pkg.sv
// Shared types for the memory request scheduler.
// Channel FSM states and request operation encoding.
package mem_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESPOND
    } ch_state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

endpackage

// File: rtl/mem_sched_channel.sv
// One memory channel: latches a granted request, runs the memory
// handshake and holds the consumer response until the consumer lets go.
module mem_sched_channel
    import mem_sched_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int CW        = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_grant,
    input  logic [CW-1:0]        i_cons,
    input  op_e                  i_op,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_BITS-1:0] i_wdata,
    input  logic                 i_cons_valid,
    input  logic                 mem_read_ready,
    input  logic                 mem_write_ready,
    output ch_state_e            o_state,
    output logic [CW-1:0]        o_cons,
    output op_e                  o_op,
    output logic                 o_done,
    output logic                 o_release,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data
);

    ch_state_e            r_state;
    ch_state_e            w_next;
    logic [CW-1:0]        r_cons;
    op_e                  r_op;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_wdata;
    logic                 w_mem_ready;

    assign w_mem_ready = (r_op == OP_READ) ? mem_read_ready : mem_write_ready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cons  <= '0;
            r_op    <= OP_READ;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (i_grant) begin
            r_cons  <= i_cons;
            r_op    <= i_op;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end
    end

    always_comb begin
        w_next    = r_state;
        o_done    = 1'b0;
        o_release = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_grant) w_next = ISSUE;
            end
            ISSUE: begin
                if (w_mem_ready) begin
                    w_next = RESPOND;
                    o_done = 1'b1;
                end
            end
            RESPOND: begin
                if (!i_cons_valid) begin
                    w_next    = IDLE;
                    o_release = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Memory-side outputs are zero whenever no request is outstanding.
    assign mem_read_valid    = (r_state == ISSUE) && (r_op == OP_READ);
    assign mem_write_valid   = (r_state == ISSUE) && (r_op == OP_WRITE);
    assign mem_read_address  = mem_read_valid ? r_addr : '0;
    assign mem_write_address = mem_write_valid ? r_addr : '0;
    assign mem_write_data    = mem_write_valid ? r_wdata : '0;

    assign o_state = r_state;
    assign o_cons  = r_cons;
    assign o_op    = r_op;

endmodule

// File: rtl/mem_scheduler.sv
// Round-robin consumer arbiter feeding NUM_CHANNELS memory channels.
// Optional grant counter enabled by defining MEM_SCHED_PERF_EN.
module mem_scheduler
    import mem_sched_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]  mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0]  mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS],
    output logic [DATA_BITS-1:0]     mem_write_data [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_write_ready
`ifdef MEM_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_grant_count
`endif
);

    localparam int CW = $clog2(NUM_CONSUMERS);
    localparam int HW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CONSUMERS-1:0] r_assigned;
    logic [NUM_CONSUMERS-1:0] w_pending;
    logic [CW-1:0]            r_rr;
    logic [DATA_BITS-1:0]     r_rdata [NUM_CONSUMERS];

    ch_state_e                w_state   [NUM_CHANNELS];
    logic [CW-1:0]            w_cons    [NUM_CHANNELS];
    op_e                      w_op      [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  w_done;
    logic [NUM_CHANNELS-1:0]  w_release;
    logic [NUM_CHANNELS-1:0]  w_cvalid;

    logic                     w_found;
    logic                     w_free;
    logic                     w_grant;
    logic [CW-1:0]            w_idx;
    logic [CW-1:0]            w_gcons;
    logic [HW-1:0]            w_gch;
    op_e                      w_gop;
    logic [ADDR_BITS-1:0]     w_gaddr;
    logic [DATA_BITS-1:0]     w_gwdata;

    assign w_pending = (consumer_read_valid | consumer_write_valid) & ~r_assigned;

    // Rotating scan from r_rr; lowest-index idle channel takes the grant.
    always_comb begin
        w_found = 1'b0;
        w_gcons = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            w_idx = CW'((int'(r_rr) + k) % NUM_CONSUMERS);
            if (!w_found && w_pending[w_idx]) begin
                w_found = 1'b1;
                w_gcons = w_idx;
            end
        end
        w_free = 1'b0;
        w_gch  = '0;
        for (int h = NUM_CHANNELS - 1; h >= 0; h--) begin
            if (w_state[h] == IDLE) begin
                w_free = 1'b1;
                w_gch  = HW'(h);
            end
        end
        w_grant  = w_found && w_free;
        w_gop    = consumer_read_valid[w_gcons] ? OP_READ : OP_WRITE;
        w_gaddr  = (w_gop == OP_READ) ? consumer_read_address[w_gcons]
                                      : consumer_write_address[w_gcons];
        w_gwdata = consumer_write_data[w_gcons];
    end

    for (genvar h = 0; h < NUM_CHANNELS; h++) begin : g_ch
        assign w_cvalid[h] = (w_op[h] == OP_READ)
                           ? consumer_read_valid[w_cons[h]]
                           : consumer_write_valid[w_cons[h]];

        mem_sched_channel #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .CW        (CW)
        ) u_ch (
            .clk               (clk),
            .reset             (reset),
            .i_grant           (w_grant && (w_gch == HW'(h))),
            .i_cons            (w_gcons),
            .i_op              (w_gop),
            .i_addr            (w_gaddr),
            .i_wdata           (w_gwdata),
            .i_cons_valid      (w_cvalid[h]),
            .mem_read_ready    (mem_read_ready[h]),
            .mem_write_ready   (mem_write_ready[h]),
            .o_state           (w_state[h]),
            .o_cons            (w_cons[h]),
            .o_op              (w_op[h]),
            .o_done            (w_done[h]),
            .o_release         (w_release[h]),
            .mem_read_valid    (mem_read_valid[h]),
            .mem_read_address  (mem_read_address[h]),
            .mem_write_valid   (mem_write_valid[h]),
            .mem_write_address (mem_write_address[h]),
            .mem_write_data    (mem_write_data[h])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_assigned <= '0;
            r_rr       <= '0;
            for (int c = 0; c < NUM_CONSUMERS; c++) r_rdata[c] <= '0;
        end else begin
            for (int h = 0; h < NUM_CHANNELS; h++) begin
                if (w_release[h]) r_assigned[w_cons[h]] <= 1'b0;
                if (w_done[h] && (w_op[h] == OP_READ))
                    r_rdata[w_cons[h]] <= mem_read_data[h];
            end
            if (w_grant) begin
                r_assigned[w_gcons] <= 1'b1;
                r_rr <= (w_gcons == CW'(NUM_CONSUMERS - 1)) ? '0 : w_gcons + 1'b1;
            end
        end
    end

    always_comb begin
        consumer_read_ready  = '0;
        consumer_write_ready = '0;
        for (int h = 0; h < NUM_CHANNELS; h++) begin
            if (w_state[h] == RESPOND) begin
                if (w_op[h] == OP_READ) consumer_read_ready[w_cons[h]]  = 1'b1;
                else                    consumer_write_ready[w_cons[h]] = 1'b1;
            end
        end
    end

    assign consumer_read_data = r_rdata;

`ifdef MEM_SCHED_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (reset)                        r_perf <= '0;
        else if (w_grant && ~&r_perf)     r_perf <= r_perf + 32'd1;
    end

    assign perf_grant_count = r_perf;
`endif

endmodule

// File: tb/tb_mem_scheduler.sv
// Bench for mem_scheduler: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a reference model.
module tb_mem_scheduler;

    localparam int N  = 4;
    localparam int M  = 2;
    localparam int AB = 8;
    localparam int DB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  crv, cwv, crr, cwr;
    logic [AB-1:0] cra [N];
    logic [AB-1:0] cwa [N];
    logic [DB-1:0] cwd [N];
    logic [DB-1:0] crd [N];
    logic [M-1:0]  mrv, mrr, mwv, mwr;
    logic [AB-1:0] mra [M];
    logic [AB-1:0] mwa [M];
    logic [DB-1:0] mrd [M];
    logic [DB-1:0] mwd [M];
`ifdef MEM_SCHED_PERF_EN
    logic [31:0]   perf;
`endif

    always #5 clk = ~clk;

    mem_scheduler #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N), .NUM_CHANNELS(M)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (crv),
        .consumer_read_address  (cra),
        .consumer_read_ready    (crr),
        .consumer_read_data     (crd),
        .consumer_write_valid   (cwv),
        .consumer_write_address (cwa),
        .consumer_write_data    (cwd),
        .consumer_write_ready   (cwr),
        .mem_read_valid         (mrv),
        .mem_read_address       (mra),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mwv),
        .mem_write_address      (mwa),
        .mem_write_data         (mwd),
        .mem_write_ready        (mwr)
`ifdef MEM_SCHED_PERF_EN
        ,
        .perf_grant_count       (perf)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Memory: 0 = zero-wait, 1 = random waits, 2 = never ready
    int            mem_mode = 0;
    logic [DB-1:0] mem [256];
    bit            mem_w [256];

    function automatic logic [DB-1:0] dflt(input logic [AB-1:0] a);
        return {a + 8'h02, a + 8'h24};
    endfunction

    always @(negedge clk) begin
        for (int h = 0; h < M; h++) begin
            mrr[h] = mrv[h] && (mem_mode == 0 ||
                     (mem_mode == 1 && $urandom_range(0, 2) != 0));
            mrd[h] = mrr[h] ? (mem_w[mra[h]] ? mem[mra[h]] : dflt(mra[h]))
                            : DB'($urandom);
            mwr[h] = mwv[h] && (mem_mode == 0 ||
                     (mem_mode == 1 && $urandom_range(0, 2) != 0));
            if (mwr[h]) begin
                mem[mwa[h]]   = mwd[h];
                mem_w[mwa[h]] = 1'b1;
            end
        end
    end

    // Reference model: channel phase 0 free, 1 waiting on memory, 2 answering
    int            m_st   [M];
    int            m_cons [M];
    bit            m_rd   [M];
    logic [AB-1:0] m_addr [M];
    logic [DB-1:0] m_wd   [M];
    bit            m_asg  [N];
    logic [DB-1:0] m_data [N];
    int            m_rr;
    longint        m_grants;
    bit            seen_edge = 0;

    always @(posedge clk) begin : model
        int nst [M];
        int free_ch;
        int pick;
        int c;
        seen_edge = 1;
        if (reset) begin
            for (int h = 0; h < M; h++) m_st[h] = 0;
            for (int k = 0; k < N; k++) begin
                m_asg[k]  = 0;
                m_data[k] = '0;
            end
            m_rr     = 0;
            m_grants = 0;
        end else begin
            nst     = m_st;
            free_ch = -1;
            for (int h = M - 1; h >= 0; h--) if (m_st[h] == 0) free_ch = h;
            pick = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (pick < 0 && (crv[c] || cwv[c]) && !m_asg[c]) pick = c;
            end
            for (int h = 0; h < M; h++) begin
                if (m_st[h] == 1 && (m_rd[h] ? mrr[h] : mwr[h])) begin
                    nst[h] = 2;
                    if (m_rd[h]) m_data[m_cons[h]] = mrd[h];
                end else if (m_st[h] == 2 &&
                             !(m_rd[h] ? crv[m_cons[h]] : cwv[m_cons[h]])) begin
                    nst[h] = 0;
                    m_asg[m_cons[h]] = 0;
                end
            end
            if (pick >= 0 && free_ch >= 0) begin
                nst[free_ch]    = 1;
                m_cons[free_ch] = pick;
                m_rd[free_ch]   = crv[pick];
                m_addr[free_ch] = crv[pick] ? cra[pick] : cwa[pick];
                m_wd[free_ch]   = cwd[pick];
                m_asg[pick]     = 1;
                m_rr            = (pick + 1) % N;
                m_grants++;
            end
            m_st = nst;
        end
    end

    always @(negedge clk) begin : compare
        bit er, ew, rr_e, wr_e;
        if (seen_edge) begin
            for (int h = 0; h < M; h++) begin
                er = (m_st[h] == 1) && m_rd[h];
                ew = (m_st[h] == 1) && !m_rd[h];
                chk($sformatf("mem_read_valid[%0d]", h), 64'(mrv[h]), 64'(er));
                chk($sformatf("mem_write_valid[%0d]", h), 64'(mwv[h]), 64'(ew));
                if (er) chk($sformatf("mem_read_address[%0d]", h), 64'(mra[h]), 64'(m_addr[h]));
                if (ew) begin
                    chk($sformatf("mem_write_address[%0d]", h), 64'(mwa[h]), 64'(m_addr[h]));
                    chk($sformatf("mem_write_data[%0d]", h), 64'(mwd[h]), 64'(m_wd[h]));
                end
            end
            for (int k = 0; k < N; k++) begin
                rr_e = 0;
                wr_e = 0;
                for (int h = 0; h < M; h++) begin
                    if (m_st[h] == 2 && m_cons[h] == k) begin
                        if (m_rd[h]) rr_e = 1;
                        else         wr_e = 1;
                    end
                end
                chk($sformatf("consumer_read_ready[%0d]", k), 64'(crr[k]), 64'(rr_e));
                chk($sformatf("consumer_write_ready[%0d]", k), 64'(cwr[k]), 64'(wr_e));
                chk($sformatf("consumer_read_data[%0d]", k), 64'(crd[k]), 64'(m_data[k]));
            end
`ifdef MEM_SCHED_PERF_EN
            chk("perf_grant_count", 64'(perf),
                64'((m_grants > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_grants));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        crv   = '0;
        cwv   = '0;
        for (int k = 0; k < N; k++) begin
            cra[k] = '0;
            cwa[k] = '0;
            cwd[k] = '0;
        end
        repeat (3) tick();
        chk("reset read_ready", 64'(crr), 64'h0);
        chk("reset mem_read_valid", 64'(mrv), 64'h0);
        chk("reset read_data[2]", 64'(crd[2]), 64'h0);

        // Single read from consumer 2
        reset  = 1'b0;
        cra[2] = 8'h10;
        crv[2] = 1'b1;
        tick();
        chk("t1 mem_read_valid", 64'(mrv), 64'h1);
        chk("t1 mem_read_address", 64'(mra[0]), 64'h10);
        chk("t1 early ready", 64'(crr), 64'h0);
        tick();
        chk("t1 read_ready", 64'(crr), 64'h4);
        chk("t1 read_data", 64'(crd[2]), 64'h1234);
        crv[2] = 1'b0;
        tick();
        chk("t1 ready drop", 64'(crr), 64'h0);

        // All four read at once on two channels
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < N; k++) cra[k] = 8'(8'h40 + k);
        crv = 4'hF;
        tick();
        chk("t2 p0 valid", 64'(mrv), 64'h1);
        chk("t2 p0 addr0", 64'(mra[0]), 64'h40);
        tick();
        chk("t2 p1 valid", 64'(mrv), 64'h2);
        chk("t2 p1 addr1", 64'(mra[1]), 64'h41);
        chk("t2 p1 ready", 64'(crr), 64'h1);
        chk("t2 p1 data0", 64'(crd[0]), 64'h4264);
        tick();
        chk("t2 p2 ready", 64'(crr), 64'h3);
        chk("t2 p2 valid", 64'(mrv), 64'h0);
        chk("t2 p2 data1", 64'(crd[1]), 64'h4365);
        crv[0] = 1'b0;
        crv[1] = 1'b0;
        tick();
        chk("t2 p3 ready", 64'(crr), 64'h0);
        chk("t2 p3 valid", 64'(mrv), 64'h0);
        tick();
        chk("t2 p4 valid", 64'(mrv), 64'h1);
        chk("t2 p4 addr0", 64'(mra[0]), 64'h42);
        tick();
        chk("t2 p5 valid", 64'(mrv), 64'h2);
        chk("t2 p5 addr1", 64'(mra[1]), 64'h43);
        chk("t2 p5 ready", 64'(crr), 64'h4);
        tick();
        chk("t2 p6 ready", 64'(crr), 64'hC);
        chk("t2 p6 data3", 64'(crd[3]), 64'h4567);
        crv = '0;
        tick();

        // Write from consumer 1
        cwa[1] = 8'h22;
        cwd[1] = 16'hBEEF;
        cwv[1] = 1'b1;
        tick();
        chk("t3 write_valid", 64'(mwv), 64'h1);
        chk("t3 write_addr", 64'(mwa[0]), 64'h22);
        chk("t3 write_data", 64'(mwd[0]), 64'hBEEF);
        chk("t3 no read", 64'(mrv), 64'h0);
        tick();
        chk("t3 write_ready", 64'(cwr), 64'h2);
        chk("t3 no read_ready", 64'(crr), 64'h0);
        cwv[1] = 1'b0;
        tick();
        chk("t3 ready drop", 64'(cwr), 64'h0);

        // Read and write together from consumer 0: read first
        cra[0] = 8'h22;
        crv[0] = 1'b1;
        cwa[0] = 8'h30;
        cwd[0] = 16'h5555;
        cwv[0] = 1'b1;
        tick();
        chk("t4 read first", 64'(mrv), 64'h1);
        chk("t4 write held", 64'(mwv), 64'h0);
        chk("t4 read addr", 64'(mra[0]), 64'h22);
        tick();
        chk("t4 read_ready", 64'(crr), 64'h1);
        chk("t4 write_ready low", 64'(cwr), 64'h0);
        chk("t4 read back", 64'(crd[0]), 64'hBEEF);
        crv[0] = 1'b0;
        tick();
        chk("t4 released rd", 64'(crr), 64'h0);
        chk("t4 released wv", 64'(mwv), 64'h0);
        tick();
        chk("t4 write_valid", 64'(mwv), 64'h1);
        chk("t4 write addr", 64'(mwa[0]), 64'h30);
        chk("t4 write data", 64'(mwd[0]), 64'h5555);
        tick();
        chk("t4 write_ready", 64'(cwr), 64'h1);
        cwv[0] = 1'b0;
        tick();
        chk("t4 write drop", 64'(cwr), 64'h0);
`ifdef MEM_SCHED_PERF_EN
        chk("perf after directed", 64'(perf), 64'd7);
`endif

        // Reset while a channel waits on memory
        mem_mode = 2;
        cra[1]   = 8'h50;
        crv[1]   = 1'b1;
        tick();
        chk("t5 issue", 64'(mrv), 64'h1);
        reset  = 1'b1;
        crv[1] = 1'b0;
        tick();
        chk("t5 valid cleared", 64'(mrv), 64'h0);
        chk("t5 ready cleared", 64'(crr), 64'h0);
        reset    = 1'b0;
        mem_mode = 0;
        cra[0]   = 8'h60;
        cra[3]   = 8'h63;
        crv      = 4'b1001;
        tick();
        chk("t5 rr restart valid", 64'(mrv), 64'h1);
        chk("t5 rr restart addr", 64'(mra[0]), 64'h60);
        tick();
        chk("t5 second grant", 64'(mra[1]), 64'h63);
        chk("t5 served", 64'(crr), 64'h1);
        crv = '0;
        repeat (2) tick();

        // Randomized traffic
        mem_mode = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 2000) begin
                reset = 1'b1;
                crv   = '0;
                cwv   = '0;
            end else begin
                reset = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!crv[k] && !cwv[k]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            int kind;
                            kind   = $urandom_range(0, 2);
                            cra[k] = AB'($urandom);
                            cwa[k] = AB'($urandom);
                            cwd[k] = DB'($urandom);
                            crv[k] = (kind != 1);
                            cwv[k] = (kind != 0);
                        end
                    end else begin
                        if (crv[k] && crr[k] && $urandom_range(0, 1) == 1) crv[k] = 1'b0;
                        if (cwv[k] && cwr[k] && $urandom_range(0, 1) == 1) cwv[k] = 1'b0;
                    end
                end
            end
            tick();
        end
        crv = '0;
        cwv = '0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
